// File: rtl/gen_scheduler_pkg.sv
// Shared types and constants for the generation scheduler and its frame pacer.
package gen_scheduler_pkg;

  localparam int SPEED_MAX = 15;

  typedef logic [3:0] speed_t;

  typedef enum logic [2:0] {
    IDLE,
    COMPUTE,
    WAIT_FRAME,
    SWAP,
    WAIT_READY
  } sched_state_t;

endpackage

// File: rtl/gen_scheduler_frame_pacer.sv
// Frame pacer: counts displayed frames while idle and decides when the next generation may start.
module gen_scheduler_frame_pacer
  import gen_scheduler_pkg::*;
(
  input  logic   clk_in,
  input  logic   rst_in,
  input  logic   count_en,
  input  logic   clear,
  input  logic   render_done,
  input  speed_t speed,
  input  logic   step_pending,
  output logic   trigger
);

  localparam int CNT_W = $clog2(SPEED_MAX + 2);
  localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(SPEED_MAX + 1);

  logic [CNT_W-1:0] frame_cnt;
  logic [CNT_W-1:0] frames_needed;

  always_ff @(posedge clk_in) begin
    if (rst_in || clear) begin
      frame_cnt <= '0;
    end else if (count_en && render_done && (frame_cnt != CNT_SAT)) begin
      frame_cnt <= frame_cnt + 1'b1;
    end
  end

  // Compared against the live speed every cycle, so a speed raise can fire at once.
  assign frames_needed = CNT_SAT - CNT_W'(speed);
  assign trigger       = (speed != '0) ? (frame_cnt >= frames_needed) : step_pending;

endmodule

// File: rtl/gen_scheduler.sv
// Generation scheduler: paces Game-of-Life generations against video frames and
// sequences life_logic start, frame-aligned buffer swap and buffer settle.
//   state      | meaning
//   IDLE       | counting frames, waiting for pace trigger or pending step
//   COMPUTE    | life_logic running, watchdog active
//   WAIT_FRAME | generation done, holding swap until the next frame end
//   SWAP       | one-cycle buffer swap, generation counted
//   WAIT_READY | waiting for the double buffer to settle, watchdog active
module gen_scheduler
  import gen_scheduler_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 2_000_000,
  parameter int GEN_WIDTH      = 16
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  speed_t               speed_in,
  input  logic                 step_in,
  input  logic                 render_done_in,
  input  logic                 logic_done_in,
  input  logic                 buf_ready_in,
  output logic                 logic_start_out,
  output logic                 buf_swap_out,
  output logic                 busy_out,
  output logic [GEN_WIDTH-1:0] gen_count_out,
  output logic                 timeout_out
);

  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  sched_state_t         state;
  sched_state_t         state_nxt;
  logic [WD_W-1:0]      watchdog;
  logic [GEN_WIDTH-1:0] gen_count;
  logic                 step_pending;
  logic                 trigger;
  logic                 start_fire;
  logic                 wd_active;
  logic                 wd_expire;
  logic                 frame_clr;

  gen_scheduler_frame_pacer u_frame_pacer (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .count_en     (state == IDLE),
    .clear        (frame_clr),
    .render_done  (render_done_in),
    .speed        (speed_in),
    .step_pending (step_pending),
    .trigger      (trigger)
  );

  assign start_fire = (state == IDLE) && trigger;
  assign wd_active  = (state == COMPUTE) || (state == WAIT_READY);
  assign wd_expire  = wd_active && (watchdog == WD_LAST);

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    frame_clr = 1'b0;
    case (state)
      IDLE:       if (start_fire) state_nxt = COMPUTE;
      // Watchdog abort outranks a same-cycle done/ready.
      COMPUTE:    if (wd_expire) state_nxt = IDLE;
                  else if (logic_done_in) state_nxt = WAIT_FRAME;
      WAIT_FRAME: if (render_done_in) state_nxt = SWAP;
      SWAP:       state_nxt = WAIT_READY;
      WAIT_READY: if (wd_expire || buf_ready_in) state_nxt = IDLE;
      default:    state_nxt = IDLE;
    endcase
    if ((state != IDLE) && (state_nxt == IDLE)) frame_clr = 1'b1;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      logic_start_out <= 1'b0;
      buf_swap_out    <= 1'b0;
      timeout_out     <= 1'b0;
      gen_count       <= '0;
      watchdog        <= '0;
      step_pending    <= 1'b0;
    end else begin
      logic_start_out <= start_fire;
      buf_swap_out    <= (state_nxt == SWAP);
      if (state_nxt == SWAP) gen_count <= gen_count + 1'b1;
      if (wd_expire) timeout_out <= 1'b1;
      if (start_fire) begin
        watchdog <= '0;
      end else if (wd_active) begin
        watchdog <= watchdog + 1'b1;
      end
      // A new step request wins over the one being consumed this cycle.
      if (speed_in != '0) begin
        step_pending <= 1'b0;
      end else if (step_in) begin
        step_pending <= 1'b1;
      end else if (start_fire) begin
        step_pending <= 1'b0;
      end
    end
  end

  assign busy_out      = (state != IDLE);
  assign gen_count_out = gen_count;

endmodule
